// File: rtl/game_tick_scheduler_if.sv
// rtl/game_tick_scheduler_if.sv - control/tick bundle between game FSM (master) and tick scheduler (slave)
interface game_tick_scheduler_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic       turbo;
    logic [3:0] level;
    logic       alien_tick;
    logic       bomb_tick;
    logic       missile_tick;
    logic       running;

    modport master (
        output start, stop, pause, turbo, level,
        input  alien_tick, bomb_tick, missile_tick, running
    );

    modport slave (
        input  start, stop, pause, turbo, level,
        output alien_tick, bomb_tick, missile_tick, running
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - master prescaler plus per-object step pulses with run/pause/stop sequencing
// FAST_SIM_EN: when defined, the base divider is forced to 20 clocks (turbo divider 2).
module game_tick_scheduler #(
    parameter int BASE_DIV         = 500000,
    parameter int ALIEN_PERIOD0    = 50,
    parameter int ALIEN_MIN_PERIOD = 5,
    parameter int LEVEL_STEP       = 5,
    parameter int BOMB_PERIOD      = 120,
    parameter int MISSILE_PERIOD   = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    game_tick_scheduler_if.slave  bus
);

`ifdef FAST_SIM_EN
    localparam int DIV = 20;
`else
    localparam int DIV = BASE_DIV;
`endif
    localparam int DIV_T = (DIV / 10 > 1) ? DIV / 10 : 1;
    localparam int PW    = $clog2(DIV + 1);

    localparam logic signed [8:0] AP0_S  = 9'(ALIEN_PERIOD0);
    localparam logic signed [8:0] STEP_S = 9'(LEVEL_STEP);
    localparam logic signed [8:0] MIN_S  = 9'(ALIEN_MIN_PERIOD);
    localparam logic [7:0]        BOMB_P    = 8'(BOMB_PERIOD);
    localparam logic [7:0]        MISSILE_P = 8'(MISSILE_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     pcnt, div_m1;
    logic              base_tick, bt_now, go;
    logic [7:0]        alien_cnt, bomb_cnt, missile_cnt, alien_period;
    logic signed [8:0] lvl_s, ap_raw;
    logic              alien_tick_q, bomb_tick_q, missile_tick_q, running_q;

    function automatic logic fire(input logic [7:0] cnt, input logic [7:0] period);
        fire = ({1'b0, cnt} + 9'd1) >= {1'b0, period};
    endfunction

    assign div_m1 = bus.turbo ? PW'(DIV_T - 1) : PW'(DIV - 1);
    assign bt_now = pcnt >= div_m1;

    assign lvl_s  = $signed({5'd0, bus.level});
    assign ap_raw = AP0_S - STEP_S * lvl_s;

    always_comb begin
        alien_period = ap_raw[7:0];
        if (ap_raw < MIN_S)
            alien_period = MIN_S[7:0];
        if (alien_period == 8'd0)
            alien_period = 8'd1;
    end

    always_comb begin
        state_nxt = state;
        if (bus.stop)
            state_nxt = S_IDLE;
        else begin
            case (state)
                S_IDLE:   if (bus.start)  state_nxt = S_RUN;
                S_RUN:    if (bus.pause)  state_nxt = S_PAUSED;
                S_PAUSED: if (!bus.pause) state_nxt = S_RUN;
                default:                  state_nxt = S_IDLE;
            endcase
        end
    end

    // The resume edge counts as a running edge so a pause shifts the schedule by exactly its length.
    assign go = !bus.stop && !bus.pause && (state == S_RUN || state == S_PAUSED);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= S_IDLE;
            running_q      <= 1'b0;
            pcnt           <= '0;
            base_tick      <= 1'b0;
            alien_cnt      <= 8'd0;
            bomb_cnt       <= 8'd0;
            missile_cnt    <= 8'd0;
            alien_tick_q   <= 1'b0;
            bomb_tick_q    <= 1'b0;
            missile_tick_q <= 1'b0;
        end else begin
            state          <= state_nxt;
            running_q      <= (state_nxt == S_RUN);
            alien_tick_q   <= 1'b0;
            bomb_tick_q    <= 1'b0;
            missile_tick_q <= 1'b0;
            if (!go) begin
                if (state_nxt == S_IDLE) begin
                    pcnt        <= '0;
                    base_tick   <= 1'b0;
                    alien_cnt   <= 8'd0;
                    bomb_cnt    <= 8'd0;
                    missile_cnt <= 8'd0;
                end
            end else begin
                pcnt      <= bt_now ? '0 : pcnt + 1'b1;
                base_tick <= bt_now;
                if (base_tick) begin
                    alien_tick_q   <= fire(alien_cnt, alien_period);
                    alien_cnt      <= fire(alien_cnt, alien_period) ? 8'd0 : alien_cnt + 8'd1;
                    bomb_tick_q    <= fire(bomb_cnt, BOMB_P);
                    bomb_cnt       <= fire(bomb_cnt, BOMB_P) ? 8'd0 : bomb_cnt + 8'd1;
                    missile_tick_q <= fire(missile_cnt, MISSILE_P);
                    missile_cnt    <= fire(missile_cnt, MISSILE_P) ? 8'd0 : missile_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.alien_tick   = alien_tick_q;
    assign bus.bomb_tick    = bomb_tick_q;
    assign bus.missile_tick = missile_tick_q;
    assign bus.running      = running_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - directed vector bench for game_tick_scheduler (base divider 20)
module tb_game_tick_scheduler;
    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    game_tick_scheduler_if bus();

    game_tick_scheduler #(.BASE_DIV(20)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   level;
        logic turbo;
        int   sel;
        int   first;
        int   period;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return bus.missile_tick;
            1:       return bus.alien_tick;
            default: return bus.bomb_tick;
        endcase
    endfunction

    function automatic logic any_out();
        return bus.missile_tick | bus.alien_tick | bus.bomb_tick | bus.running;
    endfunction

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_for(input int sel, input int limit, output int n);
        int i;
        n = -1;
        i = 0;
        while (n < 0 && i < limit) begin
            i++;
            @(posedge clk);
            #1;
            if (sel_sig(sel)) n = i;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        step(1);
    endtask

    initial begin
        int n;
        int seen;

        vecs[0] = '{0,  1'b0, 0, 41,   40};
        vecs[1] = '{0,  1'b0, 1, 1001, 1000};
        vecs[2] = '{9,  1'b0, 1, 101,  100};
        vecs[3] = '{15, 1'b0, 1, 101,  100};
        vecs[4] = '{2,  1'b0, 1, 801,  800};
        vecs[5] = '{0,  1'b1, 0, 5,    4};

        resetN    = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        bus.turbo = 1'b0;
        bus.level = 4'd0;
        step(3);
        check("reset_alien",   int'(bus.alien_tick),   0);
        check("reset_bomb",    int'(bus.bomb_tick),    0);
        check("reset_missile", int'(bus.missile_tick), 0);
        check("reset_running", int'(bus.running),      0);
        resetN = 1'b1;

        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            seen |= int'(any_out());
        end
        check("idle_quiet", seen, 0);

        for (int v = 0; v < 6; v++) begin
            bus.level = vecs[v].level[3:0];
            bus.turbo = vecs[v].turbo;
            pulse_start();
            wait_for(vecs[v].sel, vecs[v].first + 20, n);
            check($sformatf("vec%0d_first", v), n, vecs[v].first);
            check($sformatf("vec%0d_running", v), int'(bus.running), 1);
            wait_for(vecs[v].sel, vecs[v].period + 20, n);
            check($sformatf("vec%0d_period", v), n, vecs[v].period);
            bus.turbo = 1'b0;
            bus.level = 4'd0;
            do_stop();
        end

        // missile and bomb both fire on the same cycle at 2400 clocks
        pulse_start();
        wait_for(2, 2500, n);
        check("bomb_first", n, 2401);
        check("bomb_missile_coincide", int'(bus.missile_tick), 1);
        do_stop();

        pulse_start();
        wait_for(0, 60, n);
        check("pause_pre_first", n, 41);
        step(10);
        bus.pause = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            seen |= int'(any_out());
        end
        bus.pause = 1'b0;
        check("pause_quiet", seen, 0);
        wait_for(0, 60, n);
        check("pause_shift", n, 30);
        do_stop();

        // turbo raised while the prescaler sits at 15
        pulse_start();
        step(15);
        bus.turbo = 1'b1;
        wait_for(0, 30, n);
        check("turbo_midcount", n, 4);
        bus.turbo = 1'b0;
        do_stop();

        // alien counter at 30 when level drops the period to 5
        pulse_start();
        step(605);
        bus.level = 4'd9;
        wait_for(1, 40, n);
        check("level_past_period", n, 16);
        wait_for(1, 120, n);
        check("level_new_period", n, 100);
        bus.level = 4'd0;
        do_stop();

        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            seen |= int'(any_out());
        end
        check("start_stop_same", seen, 0);

        pulse_start();
        step(80);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("stop_suppress_missile", int'(bus.missile_tick), 0);
        check("stop_running",          int'(bus.running),      0);
        step(1);
        pulse_start();
        wait_for(0, 60, n);
        check("restart_first", n, 41);

        #2;
        resetN = 1'b0;
        #1;
        check("areset_missile", int'(bus.missile_tick), 0);
        check("areset_running", int'(bus.running),      0);
        check("areset_alien",   int'(bus.alien_tick),   0);
        check("areset_bomb",    int'(bus.bomb_tick),    0);
        step(2);
        resetN = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
